// File: rtl/mem_stage_pkg.sv
// Shared widths, load one-hot bit positions and bundle bit maps for the memory-access stage.
package mem_stage_pkg;
  localparam int RF_ALL_W = 38;
  localparam int MEM_RF_W = 53;
  localparam int CSR_RF_W = 79;
  localparam int EXC_RF_W = 7;
  localparam int LD_OP_W  = 5;

  // ld_op one-hot layout: {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_B  = 4;
  localparam int LD_BU = 3;
  localparam int LD_H  = 2;
  localparam int LD_HU = 1;
  localparam int LD_W  = 0;

  // csr bundle layout: {csr_wr, csr_num[13:0], csr_wmask[31:0], csr_wvalue[31:0]}
  localparam int CSR_WR_BIT  = 78;
  localparam int CSR_NUM_LSB = 64;
  localparam int CSR_NUM_W   = 14;

  // exception vector bit map
  localparam int EXC_ADEF = 0;
  localparam int EXC_ALE  = 1;
  localparam int EXC_SYS  = 2;
  localparam int EXC_BRK  = 3;
  localparam int EXC_INE  = 4;
  localparam int EXC_INT  = 5;
  localparam int EXC_ERTN = 6;
endpackage

// File: rtl/load_ext.sv
// Selects the addressed byte/halfword of a loaded word and sign- or zero-extends it.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [LD_OP_W-1:0] ld_op,
  input  logic [1:0]         off,
  input  logic [31:0]        word,
  output logic [31:0]        value
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    value    = word;
    if (ld_op[LD_B])       value = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_op[LD_BU]) value = {24'd0, byte_sel};
    else if (ld_op[LD_H])  value = {{16{half_sel[15]}}, half_sel};
    else if (ld_op[LD_HU]) value = {16'd0, half_sel};
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for its data response,
// buffers and extends load data, and drops responses owed to flushed instructions.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_to_mem_valid,
  output logic                mem_allowin,
  input  logic [31:0]         ex_pc,
  input  logic [RF_ALL_W-1:0] ex_rf_all,
  input  logic [LD_OP_W-1:0]  ex_ld_op,
  input  logic                ex_mem_req,
  input  logic [CSR_RF_W-1:0] ex_csr_rf,
  input  logic [EXC_RF_W-1:0] ex_exc_rf,
  input  logic [31:0]         ex_fault_vaddr,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                cancel_exc_ertn,
  input  logic                wb_allowin,
  output logic                mem_to_wb_valid,
  output logic [31:0]         mem_pc,
  output logic [MEM_RF_W-1:0] mem_rf_all,
  output logic [CSR_RF_W-1:0] mem_csr_rf,
  output logic [EXC_RF_W-1:0] mem_exc_rf,
  output logic [31:0]         mem_fault_vaddr,
  output logic                mem_ld_pending,
  output logic                mem_exc_ertn
);
  logic                mem_valid;
  logic [31:0]         pc;
  logic [RF_ALL_W-1:0] rf_all;
  logic [LD_OP_W-1:0]  ld_op;
  logic [CSR_RF_W-1:0] csr_rf;
  logic [EXC_RF_W-1:0] exc_rf;
  logic [31:0]         fault_vaddr;
  logic                req_pend;
  logic                buf_valid;
  logic [31:0]         rdata_buf;
  logic [1:0]          discard_cnt;

  logic        mem_ready_go, accept, leave, ok_live, take, disc_inc, disc_dec;
  logic        rf_we;
  logic [31:0] ld_value, rf_wdata;

  assign mem_ready_go    = ~req_pend | buf_valid;
  assign mem_allowin     = ~mem_valid | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid & mem_ready_go & ~cancel_exc_ertn;
  assign accept          = ex_to_mem_valid & mem_allowin & ~cancel_exc_ertn;
  assign leave           = mem_to_wb_valid & wb_allowin;

  // A response is live only once every stale response owed to flushed work is consumed.
  assign ok_live  = data_sram_data_ok & (discard_cnt == 2'd0);
  assign take     = ok_live & req_pend;
  assign disc_dec = data_sram_data_ok & (discard_cnt != 2'd0);
  assign disc_inc = cancel_exc_ertn & req_pend & ~buf_valid & ~ok_live;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid   <= 1'b0;
      pc          <= '0;
      rf_all      <= '0;
      ld_op       <= '0;
      csr_rf      <= '0;
      exc_rf      <= '0;
      fault_vaddr <= '0;
      req_pend    <= 1'b0;
      buf_valid   <= 1'b0;
      rdata_buf   <= '0;
      discard_cnt <= 2'd0;
    end else begin
      if (cancel_exc_ertn)  mem_valid <= 1'b0;
      else if (mem_allowin) mem_valid <= ex_to_mem_valid;

      if (accept) begin
        pc          <= ex_pc;
        rf_all      <= ex_rf_all;
        ld_op       <= ex_ld_op;
        csr_rf      <= ex_csr_rf;
        exc_rf      <= ex_exc_rf;
        fault_vaddr <= ex_fault_vaddr;
      end

      if (cancel_exc_ertn)  req_pend <= 1'b0;
      else if (mem_allowin) req_pend <= ex_to_mem_valid & ex_mem_req;
      else if (take)        req_pend <= 1'b0;

      if (cancel_exc_ertn || leave) buf_valid <= 1'b0;
      else if (take)                buf_valid <= 1'b1;
      if (take) rdata_buf <= data_sram_rdata;

      if (disc_inc && !disc_dec)      discard_cnt <= discard_cnt + 2'd1;
      else if (disc_dec && !disc_inc) discard_cnt <= discard_cnt - 2'd1;
    end
  end

  load_ext u_load_ext (
    .ld_op (ld_op),
    .off   (rf_all[1:0]),
    .word  (rdata_buf),
    .value (ld_value)
  );

  assign rf_we    = rf_all[37] & ~(|exc_rf);
  assign rf_wdata = (|ld_op) ? ld_value : rf_all[31:0];

  assign mem_rf_all = mem_valid ? {csr_rf[CSR_WR_BIT], csr_rf[CSR_NUM_LSB +: CSR_NUM_W],
                                   rf_we, rf_all[36:32], rf_wdata} : '0;
  assign mem_pc          = pc;
  assign mem_csr_rf      = csr_rf;
  assign mem_exc_rf      = exc_rf;
  assign mem_fault_vaddr = fault_vaddr;
  assign mem_ld_pending  = mem_valid & (|ld_op) & ~buf_valid;
  assign mem_exc_ertn    = mem_valid & (|exc_rf);

  assert property (@(posedge clk) disable iff (reset) discard_cnt <= 2'd2);
endmodule
